or10_iterative_divider: RTL and testbench

Parametrised multi-cycle radix-2 restoring divider for the OR10 CPU. It replaces the external-IP divider slot and keeps the same AXI4-Stream-style operand and result channels. It adds configurable width, signed/unsigned mode, result backpressure and defined divide-by-zero behaviour. It sits beside the CPU execute stage and serves `l.div`/`l.divu`; one division is in flight at a time.

---
 rtl/or10_iterative_divider.sv | 172 +++++++++++++++++
 tb/tb_or10_iterative_divider.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/or10_iterative_divider.sv
// or10_iterative_divider: multi-cycle radix-2 restoring divider for l.div/l.divu.
// One division in flight. Operands arrive on two AXI4-Stream-style channels and
// are accepted together. The result is {quotient, remainder} on m_axis_dout.
// Optional feature macro: OR10_DIVIDER_DIVZERO_FLAG_EN adds m_axis_dout_tuser,
// which is the registered divide-by-zero flag.
module or10_iterative_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_dividend_tvalid,
  output logic                 s_axis_dividend_tready,
  input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
  input  logic                 s_axis_divisor_tvalid,
  output logic                 s_axis_divisor_tready,
  input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
  output logic                 m_axis_dout_tvalid,
  input  logic                 m_axis_dout_tready,
  output logic [2*WIDTH-1:0]   m_axis_dout_tdata
`ifdef OR10_DIVIDER_DIVZERO_FLAG_EN
  ,
  output logic                 m_axis_dout_tuser
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;   // divisor magnitude
  logic [WIDTH-1:0]   dvnd_q, dvnd_d;   // raw dividend, needed for the divide-by-zero result
  logic               negq_q, negq_d;   // quotient must be negated
  logic               negr_q, negr_d;   // remainder takes the dividend's sign
  logic               tvalid_q, tvalid_d;
  logic [2*WIDTH-1:0] tdata_q, tdata_d;

  // Both channels handshake together so a lone operand is never consumed.
  logic accept;
  assign accept = (state_q == S_IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
  assign s_axis_dividend_tready = accept;
  assign s_axis_divisor_tready  = accept;

  // Operand signs and magnitudes. The most-negative value still has a correct
  // unsigned WIDTH-bit magnitude, so the overflow case needs no special handling.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
  assign b_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
  assign a_mag = a_neg ? (~s_axis_dividend_tdata + 1'b1) : s_axis_dividend_tdata;
  assign b_mag = b_neg ? (~s_axis_divisor_tdata + 1'b1) : s_axis_divisor_tdata;

  // One restoring step: shift {rem, quo} left. Compare the WIDTH+1-bit shifted
  // remainder against the divisor. When it fits, the difference is < 2^WIDTH,
  // so a WIDTH-bit subtract gives the exact new remainder.
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign fits     = (shifted >= {1'b0, dvsr_q});
  assign rem_step = fits ? (shifted[WIDTH-1:0] - dvsr_q) : shifted[WIDTH-1:0];

  logic last_step;
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Sign fix-up. Divide-by-zero overrides it with all-ones / raw dividend.
  logic             divzero;
  logic [WIDTH-1:0] q_fix, r_fix;
  assign divzero = (dvsr_q == '0);
  assign q_fix   = divzero ? '1     : (negq_q ? (~quo_q + 1'b1) : quo_q);
  assign r_fix   = divzero ? dvnd_q : (negr_q ? (~rem_q + 1'b1) : rem_q);

  // Next-state logic for the IDLE -> CALC -> FIX -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    dvnd_d   = dvnd_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dvnd_d  = s_axis_dividend_tdata;
          dvsr_d  = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = rem_step;
        quo_d = {quo_q[WIDTH-2:0], fits};
        if (last_step) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        tdata_d  = {q_fix, r_fix};
        tvalid_d = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (m_axis_dout_tready) begin
          tvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset discards any in-flight division.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      dvnd_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      dvnd_q   <= dvnd_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis_dout_tvalid = tvalid_q;
  assign m_axis_dout_tdata  = tdata_q;

`ifdef OR10_DIVIDER_DIVZERO_FLAG_EN
  logic tuser_q;

  // Divide-by-zero flag, captured with the result and held alongside tdata.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)              tuser_q <= 1'b0;
    else if (state_q == S_FIX) tuser_q <= divzero;
  end

  assign m_axis_dout_tuser = tuser_q;
`endif

endmodule

// File: tb/tb_or10_iterative_divider.sv
// Bench for or10_iterative_divider. It runs an unsigned and a signed instance
// side by side on the same operand stream. A monitor computes the expected
// result for each accepted operand pair from plain integer arithmetic and
// checks it when the result is delivered.
module tb_or10_iterative_divider;
  localparam int W = 32;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             dvnd_v = 1'b0, dvsr_v = 1'b0;
  logic [W-1:0]     dvnd = '0, dvsr = '0;
  logic             out_rdy = 1'b0;
  logic             rnd_bp = 1'b0, bp_hold = 1'b0;

  logic             dvnd_rdy[2], dvsr_rdy[2], vld_o[2];
  logic [2*W-1:0]   dat_o[2];
`ifdef OR10_DIVIDER_DIVZERO_FLAG_EN
  logic             usr_o[2];
`endif

  int checks = 0, errors = 0;
  int cyc = 0;
  int hs_edge = 0, take_edge = 0;

  // Index 0: unsigned instance, index 1: signed instance.
  for (genvar d = 0; d < 2; d++) begin : g_dut
    or10_iterative_divider #(.WIDTH(W), .SIGNED(d == 1)) u_dut (
      .aclk                   (aclk),
      .aresetn                (aresetn),
      .s_axis_dividend_tvalid (dvnd_v),
      .s_axis_dividend_tready (dvnd_rdy[d]),
      .s_axis_dividend_tdata  (dvnd),
      .s_axis_divisor_tvalid  (dvsr_v),
      .s_axis_divisor_tready  (dvsr_rdy[d]),
      .s_axis_divisor_tdata   (dvsr),
      .m_axis_dout_tvalid     (vld_o[d]),
      .m_axis_dout_tready     (out_rdy),
`ifdef OR10_DIVIDER_DIVZERO_FLAG_EN
      .m_axis_dout_tuser      (usr_o[d]),
`endif
      .m_axis_dout_tdata      (dat_o[d])
    );
  end

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // Result backpressure: random, held low, or always ready.
  always @(posedge aclk) begin
    #1;
    out_rdy = rnd_bp ? 1'($urandom_range(0, 1)) : !bp_hold;
  end

  task automatic chk(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {divzero, quotient, remainder}. Signed results come from
  // 64-bit truncating division, so most-negative / -1 wraps naturally.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    logic [W-1:0] q, r;
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
    return {(b == 0), q, r};
  endfunction

  // Monitor and scoreboard. All sampling happens on the falling edge.
  logic [2*W:0]   expq[2][$];
  logic           stalled[2], taken[2], prev_vld[2];
  logic [2*W-1:0] held[2];

  always @(negedge aclk) begin
    logic [2*W:0] e;
    if (!aresetn) begin
      for (int d = 0; d < 2; d++) begin
        expq[d].delete();
        stalled[d] = 1'b0; taken[d] = 1'b0; prev_vld[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk("rdy_pair", 65'(dvnd_rdy[d]), 65'(dvsr_rdy[d]));
        if (dvnd_v ^ dvsr_v) chk("single_valid_rdy", 65'({dvnd_rdy[d], dvsr_rdy[d]}), 65'd0);
        if (dvnd_v && dvsr_v && dvnd_rdy[d] && dvsr_rdy[d]) begin
          expq[d].push_back(model(dvnd, dvsr, d == 1));
          if (d == 0) hs_edge = cyc + 1;
        end
        if (taken[d]) begin
          chk("tvalid_drop", 65'(vld_o[d]), 65'd0);
          taken[d] = 1'b0;
        end
        if (vld_o[d]) begin
          if (stalled[d]) chk("hold_data", 65'(dat_o[d]), 65'(held[d]));
          if (!prev_vld[d]) chk("latency", 65'(cyc - hs_edge), 65'(W + 1));
          chk("busy_rdy", 65'({dvnd_rdy[d], dvsr_rdy[d]}), 65'd0);
          if (out_rdy) begin
            if (expq[d].size() == 0) begin
              chk("unexpected_result", 65'(dat_o[d]), 65'd0);
            end else begin
              e = expq[d].pop_front();
              chk(d ? "sdata" : "udata", 65'(dat_o[d]), 65'(e[2*W-1:0]));
`ifdef OR10_DIVIDER_DIVZERO_FLAG_EN
              chk("tuser", 65'(usr_o[d]), 65'(e[2*W]));
`endif
            end
            taken[d] = 1'b1;
            stalled[d] = 1'b0;
            if (d == 0) take_edge = cyc + 1;
          end else begin
            stalled[d] = 1'b1;
            held[d] = dat_o[d];
          end
        end else if (stalled[d]) begin
          chk("tvalid_held", 65'(vld_o[d]), 65'd1);
          stalled[d] = 1'b0;
        end
        prev_vld[d] = vld_o[d];
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    @(posedge aclk); #1;
    dvnd_v = 1'b1; dvsr_v = 1'b1; dvnd = a; dvsr = b;
    for (int n = 0; n < 500; n++) begin
      @(negedge aclk);
      if (dvnd_rdy[0]) begin ok = 1'b1; break; end
    end
    if (!ok) chk("issue_timeout", 65'd0, 65'd1);
    @(posedge aclk); #1;
    dvnd_v = 1'b0; dvsr_v = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge aclk);
      if (expq[0].size() == 0 && expq[1].size() == 0 && !vld_o[0] && !vld_o[1]) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) chk("drain_timeout", 65'd0, 65'd1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit ok;
    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_tvalid", 65'(vld_o[d]), 65'd0);
      chk("rst_tdata", 65'(dat_o[d]), 65'd0);
      chk("rst_tready", 65'({dvnd_rdy[d], dvsr_rdy[d]}), 65'd0);
`ifdef OR10_DIVIDER_DIVZERO_FLAG_EN
      chk("rst_tuser", 65'(usr_o[d]), 65'd0);
`endif
    end
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Directed cases from the function description
    issue(32'd100, 32'd7);                 drain();
    issue(-32'sd7, 32'd2);                 drain();
    issue(32'd7, -32'sd2);                 drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF);   drain();
    issue(32'd5, 32'd0);                   drain();

    // Lone dividend is never consumed; the divisor joining makes one result
    @(posedge aclk); #1;
    dvnd_v = 1'b1; dvnd = 32'd20;
    repeat (5) begin
      @(negedge aclk);
      chk("lone_dividend_rdy", 65'({dvnd_rdy[0], dvsr_rdy[0]}), 65'd0);
    end
    @(posedge aclk); #1;
    dvsr_v = 1'b1; dvsr = 32'd4;
    @(negedge aclk);
    chk("joint_rdy", 65'({dvnd_rdy[0], dvsr_rdy[0], dvnd_rdy[1], dvsr_rdy[1]}), 65'hF);
    @(posedge aclk); #1;
    dvnd_v = 1'b0; dvsr_v = 1'b0;
    drain();
    ok = 1'b1;
    repeat (40) begin
      @(negedge aclk);
      if (vld_o[0] || vld_o[1]) ok = 1'b0;
    end
    chk("no_extra_result", 65'(ok), 65'd1);

    // Backpressure for 10 cycles with operands waiting, then release
    bp_hold = 1'b1;
    issue(32'd1000, 32'd3);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge aclk);
      if (vld_o[0]) begin ok = 1'b1; break; end
    end
    chk("stall_tvalid_seen", 65'(ok), 65'd1);
    fork
      begin
        repeat (10) @(posedge aclk);
        bp_hold = 1'b0;
      end
      issue(32'd77, 32'd5);
    join
    chk("accept_after_release", 65'(hs_edge - take_edge), 65'd1);
    drain();

    // Reset in the middle of CALC discards the division
    issue(32'd12345, 32'd67);
    repeat (9) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_tvalid", 65'(vld_o[d]), 65'd0);
      chk("midrst_tdata", 65'(dat_o[d]), 65'd0);
    end
    @(posedge aclk); #1 aresetn = 1'b1;
    issue(32'd9, 32'd3);
    drain();

    // Randomized operands with random result backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = '1;
        2, 3:    b = W'($urandom_range(1, 15));
        4:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(a, b);
      repeat ($urandom_range(0, 3)) @(posedge aclk);
    end
    drain();
    rnd_bp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
